// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// buffer entry layout and PC arithmetic helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, word} entries with a single-cycle flush.
// Storage is not reset; only pointers and occupancy are.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Flush beats both push and pop; a push into a full buffer needs a pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-outstanding-request memory FSM feeding a small
// instruction buffer. Define FETCH_STALL_CNT_EN to add the stall_count output.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] program_counter
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pend_pc;
    logic             discard;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_empty;
    logic             buf_full;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] occ_next;
    logic             space_after;
    logic             in_flight;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign imem_addr  = fetch_pc;
    assign inst_valid = !buf_empty;

    assign buf_pop    = inst_valid && inst_ready && !redirect;
    assign buf_push   = (state == WAIT) && imem_rsp_valid && !discard && !redirect;
    assign push_entry = '{pc: pend_pc, word: imem_rdata};

    always_comb begin
        occ_next = buf_count;
        if (buf_push) occ_next = occ_next + CNT_W'(1);
        if (buf_pop)  occ_next = occ_next - CNT_W'(1);
    end

    assign space_after = (occ_next < CNT_W'(BUF_DEPTH));

    // A request handed over on the redirect edge still returns a word that must be dropped.
    assign in_flight = ((state == WAIT) && !imem_rsp_valid) ||
                       ((state == REQ) && imem_req_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fetch_pc       <= RESET_PC;
            discard        <= 1'b0;
            imem_req_valid <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= align_word(redirect_pc);
            if (in_flight) begin
                state          <= WAIT;
                discard        <= 1'b1;
                imem_req_valid <= 1'b0;
            end else begin
                state          <= REQ;
                discard        <= 1'b0;
                imem_req_valid <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!buf_full) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        fetch_pc       <= fetch_pc + PC_STEP;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        discard <= 1'b0;
                        if (space_after) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state          <= IDLE;
                            imem_req_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == REQ) && imem_req_ready) pend_pc <= fetch_pc;
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (buf_push),
        .push_entry(push_entry),
        .pop       (buf_pop),
        .head      (head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (buf_count)
    );

    // Buffer storage is never reset, so an empty buffer shows the reset-style values.
    assign inst_data       = buf_empty ? 32'h0 : head.word;
    assign program_counter = buf_empty ? fetch_pc : head.pc;

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'h0;
        end else if (inst_ready && !inst_valid && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 redirect  input  1  branch/branch-link taken from next-PC logic; restart fetch.
REQ-006 redirect_pc  input  32  new fetch address, valid with redirect.
REQ-007 imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_rsp_valid  input  1  read data returned (one per accepted request, in order, latency >=1).
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 inst_valid  output  1  buffered instruction available downstream.
REQ-013 inst_ready  input  1  decode consumes instruction.
REQ-014 inst_data  output  32  instruction word at buffer head.
REQ-015 program_counter  output  32  address of inst_data; feeds next-PC logic.

Function
REQ-016 fetch_pc register drives imem_addr; bits [1:0] always 0.
REQ-017 FSM states: IDLE (no request outstanding), REQ (imem_req_valid high), WAIT (one request outstanding).
REQ-018 IDLE->REQ when buffer free slots minus outstanding >= 1 and not redirect.
REQ-019 REQ->WAIT on imem_req_valid && imem_req_ready; same edge fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0).
REQ-020 WAIT->REQ on imem_rsp_valid when space remains, else WAIT->IDLE; response pushed with its address into buffer.
REQ-021 At most one outstanding request; imem_req_valid, once high, stays high with stable imem_addr until accepted or redirect.
REQ-022 Buffer is FIFO of {pc, word}; inst_valid = not empty; head drives inst_data/program_counter; pop on inst_valid && inst_ready.
REQ-023 Push and pop in same cycle when full: both occur, occupancy unchanged.
REQ-024 Redirect (highest priority): buffer flushed, fetch_pc <= {redirect_pc[31:2],2'b00}, state->REQ next cycle; inst_valid low cycle after redirect.
REQ-025 Redirect while WAIT: discard flag set; that response dropped (not pushed), flag cleared on its arrival; new request not issued until drop completes.
REQ-026 Redirect coincident with pop or push: pop/push ignored, flush wins.
REQ-027 Redirect-to-first-instruction latency: imem_req_valid high 1 cycle after redirect (no pending drop).

Reset
REQ-028 On reset assertion, immediately: state IDLE, fetch_pc = RESET_PC, buffer empty, discard flag 0, imem_req_valid 0, inst_valid 0, inst_data 0, program_counter RESET_PC.
REQ-029 Reset mid-transaction abandons outstanding request; first response after deassertion is not expected and need not be handled.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN: defined adds output stall_count[31:0], incremented each cycle inst_ready high and inst_valid low, saturating at 32'hFFFF_FFFF, cleared by reset; undefined: port and counter absent, behaviour otherwise identical.

Structure
REQ-031 Shared package holds FSM state enum (IDLE/REQ/WAIT), PC_STEP = 4, RESET_PC default.
REQ-032 Buffer implemented as sub-module fetch_buffer (synchronous FIFO, flush input, count output).

Verification
REQ-033 Reset, imem ready/1-cycle latency, inst_ready=1 -> imem_addr 0,4,8,12; program_counter follows with words in order.
REQ-034 inst_ready=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 entries buffered, imem_req_valid low, no word lost on release.
REQ-035 Redirect to 0x0000_0100 while WAIT -> in-flight word dropped, next inst_valid shows program_counter 0x100.
REQ-036 redirect_pc 0x0000_0203 -> imem_addr 0x200; fetch_pc 0xFFFF_FFFC accepted -> next address 0x0000_0000.
REQ-037 Reset asserted mid-REQ -> outputs at reset values same cycle, no clock edge required.
REQ-038 FETCH_STALL_CNT_EN defined, imem_req_ready low 5 cycles with inst_ready high -> stall_count increments by >=5.
